// File: rtl/lsu_pkg.sv
// Shared size encoding, FSM state type and per-size byte count for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] split_count(input logic [1:0] size);
        case (size)
            LS_BYTE: return 3'd1;
            LS_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_misalign_detect.sv
// Combinational misalignment flag for a (size, addr[1:0]) pair; bytes never misalign.
module lsu_misalign_detect
    import lsu_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    always_comb begin
        case (size)
            LS_BYTE: misaligned = 1'b0;
            LS_HALF: misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the data memory (big-endian lanes).
// Build option LSU_UNALIGNED_EN: misaligned accesses are split into byte accesses instead of erroring.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [1:0]  mem_lscontrol,
    output logic        mem_sign_extend,
    input  logic [31:0] mem_readdata
);

    lsu_state_e  state_reg, state_next;
    logic        write_reg, write_next;
    logic [1:0]  size_reg, size_next;
    logic        signed_reg, signed_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [1:0]  size_in;
    logic        misaligned;

`ifdef LSU_UNALIGNED_EN
    logic [1:0]  count_reg, count_next;
    logic [23:0] acc_reg, acc_next;
    logic [31:0] split_word;
    logic [2:0]  lanes_left;
    logic [31:0] split_store;
    logic        last_byte;

    assign split_word  = {acc_reg, mem_readdata[7:0]};
    // Store bytes leave most-significant first, so lane i takes byte (N-1-i) of the operand.
    assign lanes_left  = split_count(size_reg) - 3'd1 - {1'b0, count_reg};
    assign split_store = wdata_reg >> {lanes_left, 3'b000};
    assign last_byte   = ({1'b0, count_reg} == (split_count(size_reg) - 3'd1));
`else
    logic        error_reg, error_next;
`endif

    assign size_in = (req_size == 2'd3) ? LS_WORD : req_size;

    lsu_misalign_detect u_misalign (
        .size       (size_in),
        .addr_lo    (req_addr[1:0]),
        .misaligned (misaligned)
    );

    always_comb begin
        state_next      = state_reg;
        write_next      = write_reg;
        size_next       = size_reg;
        signed_next     = signed_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
`ifdef LSU_UNALIGNED_EN
        count_next      = count_reg;
        acc_next        = acc_reg;
`else
        error_next      = error_reg;
`endif
        req_ready       = 1'b0;
        mem_memread     = 1'b0;
        mem_memwrite    = 1'b0;
        mem_address     = addr_reg;
        mem_writedata   = wdata_reg;
        mem_lscontrol   = size_reg;
        mem_sign_extend = signed_reg;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_next  = req_write;
                    size_next   = size_in;
                    signed_next = req_signed;
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                    rdata_next  = 32'd0;
`ifdef LSU_UNALIGNED_EN
                    if (misaligned) begin
                        state_next = SPLIT;
                        count_next = 2'd0;
                        acc_next   = 24'd0;
                    end else begin
                        state_next = ACCESS;
                    end
`else
                    error_next = misaligned;
                    state_next = misaligned ? RESP : ACCESS;
`endif
                end
            end
            ACCESS: begin
                mem_memread  = ~write_reg;
                mem_memwrite = write_reg;
                rdata_next   = write_reg ? 32'd0 : mem_readdata;
                state_next   = RESP;
            end
`ifdef LSU_UNALIGNED_EN
            SPLIT: begin
                mem_memread     = ~write_reg;
                mem_memwrite    = write_reg;
                mem_address     = addr_reg + {30'd0, count_reg};
                mem_lscontrol   = LS_BYTE;
                mem_sign_extend = 1'b0;
                mem_writedata   = split_store & 32'h0000_00FF;
                acc_next        = split_word[23:0];
                count_next      = count_reg + 2'd1;
                if (last_byte) begin
                    state_next = RESP;
                    if (write_reg)
                        rdata_next = 32'd0;
                    else if (size_reg == LS_HALF)
                        rdata_next = {{16{signed_reg & split_word[15]}}, split_word[15:0]};
                    else
                        rdata_next = split_word;
                end
            end
`endif
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            write_reg  <= 1'b0;
            size_reg   <= LS_BYTE;
            signed_reg <= 1'b0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            rdata_reg  <= 32'd0;
`ifdef LSU_UNALIGNED_EN
            count_reg  <= 2'd0;
            acc_reg    <= 24'd0;
`else
            error_reg  <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            write_reg  <= write_next;
            size_reg   <= size_next;
            signed_reg <= signed_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rdata_reg  <= rdata_next;
`ifdef LSU_UNALIGNED_EN
            count_reg  <= count_next;
            acc_reg    <= acc_next;
`else
            error_reg  <= error_next;
`endif
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
`ifdef LSU_UNALIGNED_EN
    assign resp_error = 1'b0;
`else
    assign resp_error = error_reg & resp_valid;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed steps, reset abort, held request and random traffic
// against a byte-array reference; honours LSU_UNALIGNED_EN like the design.
module tb_load_store_unit;

`ifdef LSU_UNALIGNED_EN
    localparam bit UNALIGNED = 1'b1;
`else
    localparam bit UNALIGNED = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [1:0]  mem_lscontrol;
    logic        mem_sign_extend;
    logic [31:0] mem_readdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_q   [0:63];
    logic [7:0] ref_mem [0:63];
    logic [5:0] ra;

    load_store_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_memread     (mem_memread),
        .mem_memwrite    (mem_memwrite),
        .mem_lscontrol   (mem_lscontrol),
        .mem_sign_extend (mem_sign_extend),
        .mem_readdata    (mem_readdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: combinational read with extension, write on the rising edge.
    always_comb begin
        ra = mem_address[5:0];
        mem_readdata = {mem_q[ra], mem_q[ra + 6'd1], mem_q[ra + 6'd2], mem_q[ra + 6'd3]};
        case (mem_lscontrol)
            2'd0: mem_readdata = {{24{mem_sign_extend & mem_q[ra][7]}}, mem_q[ra]};
            2'd1: mem_readdata = {{16{mem_sign_extend & mem_q[ra][7]}}, mem_q[ra], mem_q[ra + 6'd1]};
            default: ;
        endcase
    end

    always @(posedge clock) begin
        if (mem_memwrite) begin
            case (mem_lscontrol)
                2'd0: mem_q[ra] = mem_writedata[7:0];
                2'd1: begin
                    mem_q[ra]        = mem_writedata[15:8];
                    mem_q[ra + 6'd1] = mem_writedata[7:0];
                end
                default: begin
                    mem_q[ra]        = mem_writedata[31:24];
                    mem_q[ra + 6'd1] = mem_writedata[23:16];
                    mem_q[ra + 6'd2] = mem_writedata[15:8];
                    mem_q[ra + 6'd3] = mem_writedata[7:0];
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: one request applied to the byte array, with the expected outcome.
    task automatic ref_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rdata, output logic err,
                              output int n, output logic split);
        logic        mis;
        logic [31:0] v;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis   = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        split = mis && UNALIGNED;
        err   = mis && !UNALIGNED;
        rdata = 32'd0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < n; i++)
                    ref_mem[(a + i) & 32'd63] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    v = (v << 8) | {24'd0, ref_mem[(a + i) & 32'd63]};
                if (sg && n < 4 && v[8 * n - 1])
                    v = v | (32'hFFFF_FFFF << (8 * n));
                rdata = v;
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        split;
        int          n, lat, strobes, exp_cycles;
        ref_access(w, sz, sg, a, wd, exp_rdata, exp_err, n, split);
        exp_cycles = split ? n : (exp_err ? 0 : 1);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0;
        strobes = 0;
        while (!resp_valid && lat < 8) begin
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (mem_memread || mem_memwrite) begin
                check("strobe_dir", {30'd0, mem_memwrite, mem_memread}, {30'd0, w, ~w});
                if (split) begin
                    check("split_addr", mem_address, a + strobes);
                    check("split_ctrl", {29'd0, mem_lscontrol, mem_sign_extend}, 32'd0);
                    if (w)
                        check("split_wbyte", {24'd0, mem_writedata[7:0]},
                              (wd >> (8 * (n - 1 - strobes))) & 32'hFF);
                end else begin
                    check("access_addr", mem_address, a);
                    check("access_ctrl", {29'd0, mem_lscontrol, mem_sign_extend},
                          {29'd0, (sz == 2'd3) ? 2'd2 : sz, sg});
                    if (w) check("access_wdata", mem_writedata, wd);
                end
                strobes++;
            end
            @(negedge clock);
            lat++;
        end
        check("resp_latency", lat, exp_cycles);
        check("strobe_cycles", strobes, exp_cycles);
        check("resp_no_strobe", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_error", {31'd0, resp_error}, {31'd0, exp_err});
        got = resp_rdata;
        $display("TXN %s size=%0d signed=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 w ? "ST" : "LD", sz, sg, a, wd, resp_rdata, resp_error, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] exp_r;
        logic        exp_e;
        logic        sp;
        int          n_dummy, resp_seen;
        logic [5:0]  rdy_vec, rv_vec;

        for (int i = 0; i < 64; i++) begin
            mem_q[i]   = 8'($urandom);
            ref_mem[i] = mem_q[i];
        end
        {mem_q[4], mem_q[5], mem_q[6], mem_q[7]}     = 32'h8899_AABB;
        {mem_q[8], mem_q[9], mem_q[10], mem_q[11]}   = 32'h1122_3344;
        {ref_mem[4], ref_mem[5], ref_mem[6], ref_mem[7]}   = 32'h8899_AABB;
        {ref_mem[8], ref_mem[9], ref_mem[10], ref_mem[11]} = 32'h1122_3344;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", {31'd0, resp_error}, 32'd0);
        check("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);

        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, got);
        check("ld_word_4", got, 32'h8899_AABB);
        do_req(1'b0, 2'd0, 1'b1, 32'h4, 32'd0, got);
        check("ld_sbyte_4", got, 32'hFFFF_FF88);
        do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'd0, got);
        check("ld_ubyte_7", got, 32'h0000_00BB);
        do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'd0, got);
        check("ld_shalf_6", got, 32'hFFFF_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h5, 32'd0, got);
`ifdef LSU_UNALIGNED_EN
        check("ld_word_5_split", got, 32'h99AA_BB11);
`else
        check("ld_word_5_err", {resp_error, got[30:0]}, 32'h8000_0000);
`endif
        do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_1234, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, got);
        check("ld_after_hst", got, 32'h8899_1234);
        do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hDEAD_BEEF, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, got);
`ifdef LSU_UNALIGNED_EN
        check("word4_after_split_st", got, 32'h8899_DEAD);
`else
        check("word4_after_err_st", got, 32'h8899_1234);
`endif
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, got);
`ifdef LSU_UNALIGNED_EN
        check("word8_after_split_st", got, 32'hBEEF_3344);
`else
        check("word8_after_err_st", got, 32'h1122_3344);
`endif

        // Reset in the middle of a request: no response for it, back to idle.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_signed = 1'b0; req_size = 2'd2;
`ifdef LSU_UNALIGNED_EN
        req_addr = 32'h5;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
`else
        req_addr = 32'h4;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
`endif
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
        check("abort_resp", {31'd0, resp_valid}, 32'd0);
        reset_n = 1'b1;
        resp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (resp_valid) resp_seen++;
        end
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_resp", resp_seen, 32'd0);

        // Request held high: the second accept only after the first response.
        ref_access(1'b0, 2'd2, 1'b0, 32'h8, 32'd0, exp_r, exp_e, n_dummy, sp);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h8;
        for (int t = 0; t < 6; t++) begin
            rdy_vec[5 - t] = req_ready;
            rv_vec[5 - t]  = resp_valid;
            if (resp_valid) check("held_rdata", resp_rdata, exp_r);
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("held_ready_pattern", {26'd0, rdy_vec}, 32'b100100);
        check("held_resp_pattern", {26'd0, rv_vec}, 32'b001001);
        $display("TXN HELD ready=%b resp=%b", rdy_vec, rv_vec);

        for (int t = 0; t < 80; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
